// File: rtl/tdc_pkg.sv
// Shared TDC types and defaults used by the popcount statistics block.
package tdc_pkg;

    localparam int N_DEF   = 64;
    localparam int N_O_DEF = $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } stats_state_t;

    function automatic logic [15:0] clamp_hw(input logic [15:0] v,
                                             input logic [15:0] n);
        return (v > n) ? n : v;
    endfunction

endpackage

// File: rtl/tdc_minmax_acc.sv
// Running sum/min/max slice; exposes next-state values so the caller
// can capture results on the same edge as the final update.
module tdc_minmax_acc #(
    parameter int OW = 7,
    parameter int SW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          upd,
    input  logic [OW-1:0] s,
    output logic [SW-1:0] sum_nxt,
    output logic [OW-1:0] min_nxt,
    output logic [OW-1:0] max_nxt
);

    logic [SW-1:0] sum;
    logic [OW-1:0] min;
    logic [OW-1:0] max;

    assign sum_nxt = sum + SW'(s);
    assign min_nxt = (s < min) ? s : min;
    assign max_nxt = (s > max) ? s : max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            min <= '1;
            max <= '0;
        end else if (clr) begin
            sum <= '0;
            min <= '1;
            max <= '0;
        end else if (upd) begin
            sum <= sum_nxt;
            min <= min_nxt;
            max <= max_nxt;
        end
    end

endmodule

// File: rtl/tdc_hw_stats.sv
// Accumulates 2^LOG2_SAMPLES TDC popcount samples into sum/mean/min/max,
// holding the result under a valid/ready handshake.
module tdc_hw_stats
    import tdc_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int N_O          = $clog2(N),
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        start,
    input  logic                        hw_valid,
    input  logic [N_O:0]                hw,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [N_O+LOG2_SAMPLES:0]   res_sum,
    output logic [N_O:0]                res_mean,
    output logic [N_O:0]                res_min,
    output logic [N_O:0]                res_max,
    output logic                        overrange
);

    localparam int OW = N_O + 1;
    localparam int SW = OW + LOG2_SAMPLES;

    stats_state_t            state;
    logic [LOG2_SAMPLES-1:0] cnt;
    logic [OW-1:0]           s;
    logic                    over;
    logic                    go;
    logic                    clr;
    logic                    upd;
    logic                    last;
    logic [SW-1:0]           sum_nxt;
    logic [OW-1:0]           min_nxt;
    logic [OW-1:0]           max_nxt;

    assign s    = OW'(clamp_hw(16'(hw), 16'(N)));
    assign over = 16'(hw) > 16'(N);
    assign go   = start & en;
    assign last = &cnt;
    assign upd  = (state == ACCUM) & en & hw_valid;
    assign clr  = go & ((state == IDLE) |
                        ((state == DONE) & res_ready));

    tdc_minmax_acc #(
        .OW(OW),
        .SW(SW)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .upd     (upd),
        .s       (s),
        .sum_nxt (sum_nxt),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_mean  <= '0;
            res_min   <= '0;
            res_max   <= '0;
            overrange <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state     <= ACCUM;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        overrange <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        overrange <= 1'b0;
                    end else if (hw_valid) begin
                        overrange <= overrange | over;
                        if (last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            res_sum   <= sum_nxt;
                            res_mean  <= OW'(sum_nxt >> LOG2_SAMPLES);
                            res_min   <= min_nxt;
                            res_max   <= max_nxt;
                        end else begin
                            cnt <= cnt + LOG2_SAMPLES'(1);
                        end
                    end
                end
                DONE: begin
                    // en low here keeps the result until it is read out
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (go) begin
                            state     <= ACCUM;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            overrange <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tdc_hw_stats.md
Name: tdc_hw_stats

Overview:
Downstream consumer of the TDC thermometer-popcount result (hw, 0..N). It accumulates a run of 2^LOG2_SAMPLES accepted hw samples and produces sum, truncated mean, min and max. Results are held under a valid/ready handshake so a slow readout stage (scan, SPI or pin mux) can collect them. Single clock domain; the hw producer is already synchronized to clk upstream.

Parameters:
N, 64, delay-line length; hw range is 0..N
N_O, $clog2(N), derived; hw width is N_O+1
LOG2_SAMPLES, 8, log2 of samples per run (1..12)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low aborts any run
start  in  1  single-cycle request to begin a run
hw_valid  in  1  single-cycle strobe: hw carries a new sample
hw  in  N_O+1  popcount sample from TDC
busy  out  1  high in ACCUM
res_valid  out  1  result registers valid (DONE state)
res_ready  in  1  consumer accepts result
res_sum  out  N_O+1+LOG2_SAMPLES  sum of samples
res_mean  out  N_O+1  res_sum >> LOG2_SAMPLES (truncating)
res_min  out  N_O+1  minimum sample of run
res_max  out  N_O+1  maximum sample of run
overrange  out  1  sticky: a sample with hw > N was seen in this run

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, res_valid=0, all res_*=0, overrange=0, sample counter=0.
- FSM states IDLE, ACCUM, DONE.
- IDLE: start&en -> ACCUM; at that edge clear sum to 0, count to 0, min to all-ones of width N_O+1 internally, max to 0, overrange to 0. hw_valid ignored in IDLE.
- ACCUM: on each edge with hw_valid&en, sample s = (hw > N) ? N : hw (clamp); overrange set if hw > N; sum += s; min = min(min,s); max = max(max,s); count += 1.
- When the accepted sample is the 2^LOG2_SAMPLES-th (count == 2^LOG2_SAMPLES-1 before increment) -> DONE at that same edge; res_* registered from the updated values; res_valid=1 from the next cycle (latency 1 cycle after last sample).
- start in ACCUM ignored. en low in ACCUM: -> IDLE next edge, partial results discarded, res_valid stays 0.
- DONE: res_* and overrange held stable while res_valid=1 and res_ready=0. res_valid&res_ready -> IDLE; if start&en in the same cycle -> ACCUM directly (clear as above). hw_valid in DONE dropped. en low in DONE does not drop the result.
- Sum width N_O+1+LOG2_SAMPLES cannot overflow (max N*2^LOG2_SAMPLES). Mean is floor.
- Counter width LOG2_SAMPLES bits; terminal count detected, no wrap.
- res_* outputs change only on entry to DONE; reset mid-run clears everything immediately.

Decomposition:
- Package tdc_pkg: stats_state_t enum {IDLE, ACCUM, DONE}; function for clamp-to-N; shared N/N_O defaults matching tdc_top.
- One sub-module natural: tdc_minmax_acc (running min/max/sum register slice with clear and update), instanced once; FSM and counter in tdc_hw_stats.

Test Plan:
- LOG2_SAMPLES=2, run with hw=10,20,30,41 -> res_sum=101, res_mean=25, res_min=10, res_max=41, overrange=0, res_valid one cycle after 4th strobe.
- Hold res_ready=0 for 20 cycles, toggle hw_valid with varied hw -> res_* unchanged; assert res_ready -> IDLE, res_valid=0 next cycle.
- Sample hw=70 (N=64) among 64,0,5 -> clamped to 64, res_sum=133, res_max=64, res_min=0, overrange=1.
- Deassert en after 2 of 4 samples -> IDLE, no res_valid; new start then 4x hw=7 -> sum=28, mean=7, min=max=7.
- Assert start with res_ready in DONE -> busy=1 next cycle, no IDLE cycle; start during ACCUM -> no restart, count unaffected.
- Pull rst_n low mid-ACCUM asynchronously -> all outputs 0 immediately (before next clk edge).
